// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package seq_mult_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int CNT_W     = $clog2(DEF_WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mult_step.sv
// One MSB-first shift-add step: sum = (acc << 1) + (bit_in ? ma : 0), ripple-carry.
module mult_step #(
   parameter int WIDTH = 8
) (
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   ma,
   input  logic               bit_in,
   output logic [2*WIDTH-1:0] sum
);

   logic [2*WIDTH-1:0] shifted;
   logic [2*WIDTH-1:0] addend;

   assign shifted = acc << 1;
   assign addend  = bit_in ? {{WIDTH{1'b0}}, ma} : '0;

   always_comb begin
      logic carry;
      carry = 1'b0;
      sum   = '0;
      for (int i = 0; i < 2*WIDTH; i++) begin
         sum[i] = shifted[i] ^ addend[i] ^ carry;
         carry  = (shifted[i] & addend[i]) | (carry & (shifted[i] ^ addend[i]));
      end
   end

endmodule

// File: rtl/seq_mult8.sv
// Sequential unsigned multiplier with start/busy/done handshake.
// Optional leading-zero skip on the multiplier: define SEQ_MULT8_EARLY_TERM_EN.
//
// state | meaning
// IDLE  | waiting for start, no valid product yet
// BUSY  | iterating one multiplier bit per cycle
// DONE  | product valid and held; start restarts immediately
module seq_mult8
   import seq_mult_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t             state;
   state_t             state_nxt;
   logic [WIDTH-1:0]   ma;
   logic [WIDTH-1:0]   mb;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] step;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   mb_init;
   logic [CW-1:0]      cnt_init;
   logic               accept;
   logic               last;

   assign accept = start && (state != BUSY);
   assign last   = (state == BUSY) && (cnt == CW'(1));
   assign busy   = (state == BUSY);
   assign done   = (state == DONE);

   mult_step #(.WIDTH(WIDTH)) u_step (
      .acc    (acc),
      .ma     (ma),
      .bit_in (mb[WIDTH-1]),
      .sum    (step)
   );

`ifdef SEQ_MULT8_EARLY_TERM_EN
   // Skip leading zeros of b: pre-align its top set bit to the MSB.
   always_comb begin
      logic [CW-1:0] n;
      n = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (b[i]) n = CW'(i + 1);
      end
      mb_init  = b << (CW'(WIDTH) - n);
      cnt_init = (n == '0) ? CW'(1) : n;
   end
`else
   assign mb_init  = b;
   assign cnt_init = CW'(WIDTH);
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = BUSY;
         BUSY:    if (last)  state_nxt = DONE;
         DONE:    if (start) state_nxt = BUSY;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ma      <= '0;
         mb      <= '0;
         acc     <= '0;
         cnt     <= '0;
         product <= '0;
      end else if (accept) begin
         ma  <= a;
         mb  <= mb_init;
         acc <= '0;
         cnt <= cnt_init;
      end else if (state == BUSY) begin
         acc <= step;
         mb  <= mb << 1;
         cnt <= cnt - CW'(1);
         if (last) product <= step;
      end
   end

endmodule
